// File: rtl/pcileech_pcie_err_msg_tx.sv
// PCIe error Message TLP transmitter: captures error pulses into pending flags, emits
// ERR_COR/ERR_NONFATAL/ERR_FATAL messages by priority with a minimum inter-message gap.
module pcileech_pcie_err_msg_tx #(
    parameter int unsigned MIN_GAP = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_cor,
    input  logic             err_nonfatal,
    input  logic             err_ur,
    input  logic             err_fatal,
    input  logic             cmd_serr_en,
    input  logic             devctl_cor_en,
    input  logic             devctl_nf_en,
    input  logic             devctl_fatal_en,
    input  logic             devctl_ur_en,
    input  logic [15:0]      req_id,
    output logic [127:0]     tx_tdata,
    output logic [15:0]      tx_tkeep,
    output logic             tx_tlast,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic             sig_sys_err_set,
    output logic [CNT_W-1:0] msg_sent_count,
    output logic [CNT_W-1:0] coalesced_count
);
    localparam int unsigned GAP_W      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [7:0]  CODE_COR   = 8'h30;
    localparam logic [7:0]  CODE_NF    = 8'h31;
    localparam logic [7:0]  CODE_FATAL = 8'h33;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_t;

    state_t             state_q, state_d;
    logic               pend_cor_q, pend_nf_q, pend_fatal_q;
    logic               clr_cor, clr_nf, clr_fatal;
    logic               cap_cor, cap_nf, cap_fatal;
    logic [7:0]         code_q, code_d;
    logic [15:0]        rid_q, rid_d;
    logic               tvalid_q, tvalid_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               accept;
    logic               serr_q;
    logic [CNT_W-1:0]   sent_q, coal_q, coal_nxt;
    logic [1:0]         coal_inc;
    logic [CNT_W+1:0]   coal_sum;

    always_comb begin
        cap_cor   = err_cor & devctl_cor_en;
        // UR is reported as non-fatal, so it also needs the non-fatal path enabled.
        cap_nf    = (err_nonfatal | (err_ur & devctl_ur_en)) & (devctl_nf_en | cmd_serr_en);
        cap_fatal = err_fatal & (devctl_fatal_en | cmd_serr_en);
        accept    = tvalid_q & tx_tready;
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        rid_d     = rid_q;
        tvalid_d  = tvalid_q;
        gap_d     = gap_q;
        clr_cor   = 1'b0;
        clr_nf    = 1'b0;
        clr_fatal = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_fatal_q) begin
                    clr_fatal = 1'b1;
                    code_d    = CODE_FATAL;
                end else if (pend_nf_q) begin
                    clr_nf = 1'b1;
                    code_d = CODE_NF;
                end else if (pend_cor_q) begin
                    clr_cor = 1'b1;
                    code_d  = CODE_COR;
                end
                if (pend_fatal_q | pend_nf_q | pend_cor_q) begin
                    rid_d   = req_id;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (accept) begin
                    tvalid_d = 1'b0;
                    gap_d    = '0;
                    state_d  = (MIN_GAP == 0) ? StIdle : StGap;
                end else begin
                    tvalid_d = 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GAP_W'(MIN_GAP - 1)) state_d = StIdle;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // A new event on a flag that is being cleared this cycle is a fresh message, not a merge.
    always_comb begin
        coal_inc = {1'b0, cap_cor & pend_cor_q & ~clr_cor}
                 + {1'b0, cap_nf & pend_nf_q & ~clr_nf}
                 + {1'b0, cap_fatal & pend_fatal_q & ~clr_fatal};
        coal_sum = {2'b00, coal_q} + (CNT_W + 2)'(coal_inc);
        coal_nxt = (coal_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : coal_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_cor_q   <= 1'b0;
            pend_nf_q    <= 1'b0;
            pend_fatal_q <= 1'b0;
            code_q       <= '0;
            rid_q        <= '0;
            tvalid_q     <= 1'b0;
            gap_q        <= '0;
            serr_q       <= 1'b0;
            sent_q       <= '0;
            coal_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_cor_q   <= (pend_cor_q & ~clr_cor) | cap_cor;
            pend_nf_q    <= (pend_nf_q & ~clr_nf) | cap_nf;
            pend_fatal_q <= (pend_fatal_q & ~clr_fatal) | cap_fatal;
            code_q       <= code_d;
            rid_q        <= rid_d;
            tvalid_q     <= tvalid_d;
            gap_q        <= gap_d;
            serr_q       <= accept & (code_q != CODE_COR) & cmd_serr_en;
            if (accept && (sent_q != {CNT_W{1'b1}})) sent_q <= sent_q + 1'b1;
            coal_q       <= coal_nxt;
        end
    end

    always_comb begin
        tx_tvalid       = tvalid_q;
        tx_tdata        = tvalid_q ? {64'h0, rid_q, 8'h00, code_q, 32'h3000_0000} : '0;
        tx_tkeep        = {16{tvalid_q}};
        tx_tlast        = tvalid_q;
        sig_sys_err_set = serr_q;
        msg_sent_count  = sent_q;
        coalesced_count = coal_q;
    end
endmodule

// File: tb/tb_pcileech_pcie_err_msg_tx.sv
// Self-checking bench: directed scenarios plus randomized traffic against a timestamp-based
// reference model of pending flags, message selection, gap timing and saturating counters.
module tb_pcileech_pcie_err_msg_tx;
    localparam int unsigned MIN_GAP = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             err_cor = 0, err_nonfatal = 0, err_ur = 0, err_fatal = 0;
    logic             cmd_serr_en = 0, devctl_cor_en = 0, devctl_nf_en = 0;
    logic             devctl_fatal_en = 0, devctl_ur_en = 0;
    logic [15:0]      req_id = '0;
    logic [127:0]     tx_tdata;
    logic [15:0]      tx_tkeep;
    logic             tx_tlast, tx_tvalid;
    logic             tx_tready = 1'b0;
    logic             sig_sys_err_set;
    logic [CNT_W-1:0] msg_sent_count, coalesced_count;

    pcileech_pcie_err_msg_tx #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .err_cor(err_cor), .err_nonfatal(err_nonfatal), .err_ur(err_ur), .err_fatal(err_fatal),
        .cmd_serr_en(cmd_serr_en), .devctl_cor_en(devctl_cor_en), .devctl_nf_en(devctl_nf_en),
        .devctl_fatal_en(devctl_fatal_en), .devctl_ur_en(devctl_ur_en), .req_id(req_id),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready), .sig_sys_err_set(sig_sys_err_set),
        .msg_sent_count(msg_sent_count), .coalesced_count(coalesced_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: flags 0=cor 1=nonfatal 2=fatal; timing kept as cycle timestamps.
    bit          m_pend [3];
    bit          m_busy, m_valid, m_serr;
    int          cyc, m_valid_at, m_idle_from, m_sent, m_coal, m_accepts;
    logic [7:0]  m_code;
    logic [15:0] m_rid;

    logic [7:0]   dut_codes [$];
    logic [127:0] last_tdata;
    int           serr_seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit cap [3];
        bit clr [3];
        bit found;
        int n;
        if (tx_tvalid && tx_tready) dut_codes.push_back(tx_tdata[39:32]);
        cyc++;
        m_serr = 0;
        for (int i = 0; i < 3; i++) clr[i] = 0;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_pend[i] = 0;
            m_busy = 0; m_valid = 0; m_sent = 0; m_coal = 0;
            m_idle_from = 0; m_code = '0; m_rid = '0;
            return;
        end
        cap[0] = err_cor && devctl_cor_en;
        cap[1] = (err_nonfatal || (err_ur && devctl_ur_en)) && (devctl_nf_en || cmd_serr_en);
        cap[2] = err_fatal && (devctl_fatal_en || cmd_serr_en);
        if (m_busy) begin
            if (m_valid && tx_tready) begin
                m_busy      = 0;
                m_sent      = (m_sent + 1 > CMAX) ? CMAX : m_sent + 1;
                m_serr      = (m_code != 8'h30) && cmd_serr_en;
                m_idle_from = cyc + MIN_GAP + 1;
                m_accepts++;
            end
        end else if (cyc >= m_idle_from) begin
            found = 0;
            for (int i = 2; i >= 0; i--) begin
                if (!found && m_pend[i]) begin
                    found      = 1;
                    clr[i]     = 1;
                    m_code     = (i == 2) ? 8'h33 : (i == 1) ? 8'h31 : 8'h30;
                    m_rid      = req_id;
                    m_busy     = 1;
                    m_valid_at = cyc + 1;
                end
            end
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (cap[i] && m_pend[i] && !clr[i]) n++;
            m_pend[i] = (m_pend[i] && !clr[i]) || cap[i];
        end
        m_coal  = (m_coal + n > CMAX) ? CMAX : m_coal + n;
        m_valid = m_busy && (cyc >= m_valid_at);
    endtask

    task automatic compare_outputs();
        logic [127:0] exp_data;
        exp_data = m_valid ? {64'h0, m_rid, 8'h00, m_code, 32'h3000_0000} : 128'h0;
        chk("tvalid", tx_tvalid, m_valid);
        chk("tdata", tx_tdata, exp_data);
        chk("tkeep", tx_tkeep, m_valid ? 16'hFFFF : 16'h0);
        chk("tlast", tx_tlast, m_valid);
        chk("sig_sys_err_set", sig_sys_err_set, m_serr);
        chk("msg_sent_count", msg_sent_count, m_sent[CNT_W-1:0]);
        chk("coalesced_count", coalesced_count, m_coal[CNT_W-1:0]);
        if (tx_tvalid) last_tdata = tx_tdata;
        if (sig_sys_err_set) serr_seen++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
        err_cor = 0; err_nonfatal = 0; err_ur = 0; err_fatal = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_en(input logic serr, input logic cor, input logic nf, input logic fat,
                          input logic ur);
        cmd_serr_en = serr; devctl_cor_en = cor; devctl_nf_en = nf;
        devctl_fatal_en = fat; devctl_ur_en = ur;
    endtask

    task automatic do_reset();
        rst = 1;
        run(2);
        rst = 0;
        dut_codes.delete();
        serr_seen = 0;
    endtask

    initial begin
        serr_seen = 0;
        do_reset();
        chk("reset_tvalid", tx_tvalid, 1'b0);
        chk("reset_sent", msg_sent_count, '0);

        // Single correctable message with a fixed requester ID.
        set_en(0, 1, 0, 0, 0);
        req_id = 16'h0100; tx_tready = 1;
        err_cor = 1;
        run(25);
        chk("t1_tdata", last_tdata[63:0], 64'h0100_0030_3000_0000);
        chk("t1_sent", msg_sent_count, 8'd1);
        chk("t1_serr", serr_seen, 0);

        // Fatal beats correctable when both arrive together.
        do_reset();
        set_en(1, 1, 1, 1, 1);
        err_cor = 1; err_fatal = 1;
        run(60);
        chk("t2_n", dut_codes.size(), 2);
        if (dut_codes.size() >= 2) begin
            chk("t2_first", dut_codes[0], 8'h33);
            chk("t2_second", dut_codes[1], 8'h30);
        end

        // Non-fatal pulses merge while the sink stalls an earlier message.
        do_reset();
        set_en(0, 1, 1, 0, 0);
        tx_tready = 0;
        err_cor = 1;
        run(4);
        for (int i = 0; i < 3; i++) begin
            err_nonfatal = 1;
            run(2);
        end
        tx_tready = 1;
        run(60);
        chk("t3_coal", coalesced_count, 8'd2);
        chk("t3_sent", msg_sent_count, 8'd2);

        // SERR# alone: UR is suppressed, non-fatal goes out and flags system error.
        do_reset();
        set_en(1, 0, 0, 0, 0);
        err_ur = 1;
        run(10);
        chk("t4_ur_sent", msg_sent_count, 8'd0);
        err_nonfatal = 1;
        run(30);
        chk("t4_nf_sent", msg_sent_count, 8'd1);
        chk("t4_serr", serr_seen, 1);

        // Stall, then reset mid-transfer.
        do_reset();
        set_en(1, 1, 1, 1, 1);
        tx_tready = 0;
        err_fatal = 1;
        run(13);
        chk("t5_hold_valid", tx_tvalid, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk("t5_rst_valid", tx_tvalid, 1'b0);
        chk("t5_rst_sent", msg_sent_count, '0);
        chk("t5_rst_coal", coalesced_count, '0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0)
                set_en($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) != 0);
            err_cor      = ($urandom_range(0, 7) == 0);
            err_nonfatal = ($urandom_range(0, 7) == 0);
            err_ur       = ($urandom_range(0, 7) == 0);
            err_fatal    = ($urandom_range(0, 9) == 0);
            tx_tready    = ($urandom_range(0, 3) != 0);
            req_id       = 16'($urandom);
            rst          = ($urandom_range(0, 699) == 0);
            step();
            rst = 0;
        end

        // Saturation of the sent counter.
        do_reset();
        set_en(0, 0, 0, 1, 0);
        tx_tready = 1;
        m_accepts = 0;
        for (int k = 0; k < 300; k++) begin
            err_fatal = 1;
            run(MIN_GAP + 4);
        end
        chk("t6_accepts", m_accepts >= 300, 1'b1);
        chk("t6_sat", msg_sent_count, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
